// File: rtl/otter_mem_align_ctrl.sv
// otter_mem_align_ctrl
// Access sequencer between the MEM stage and data port 2 of the OTTER memory.
// Accesses that fit inside one aligned word (and all MMIO accesses) pass straight
// through. RAM loads that cross a word boundary become two word reads merged into
// one result. RAM stores that cross a word boundary become a series of byte writes.
// The pipeline is stalled for the extra cycles.
//
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_req_*                MEM-stage request (valid, we, addr, size, sign, wdata)
//   o_stall                hold the MEM stage (request stays stable while high)
//   o_rsp_valid/_rdata     load result, valid the cycle after the final read issue
//   o_misalign_err         one-cycle pulse on a rejected request
//   o_mem_*, i_mem_dout2   memory data port 2 (read data arrives one cycle after issue)
module otter_mem_align_ctrl #(
    parameter logic [31:0] IO_BASE = 32'h1100_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_sign,
    input  logic [31:0] i_req_wdata,
    output logic        o_stall,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_misalign_err,
    output logic [31:0] o_mem_addr2,
    output logic [31:0] o_mem_din2,
    output logic        o_mem_write2,
    output logic        o_mem_read2,
    output logic        o_mem_sign,
    output logic [1:0]  o_mem_size,
    input  logic [31:0] i_mem_dout2
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD2 = 2'd1, S_WRB = 2'd2} state_t;

    state_t      r_state, w_next;
    logic [1:0]  r_ctx_off, r_ctx_size;
    logic        r_ctx_sign, r_ctx_io, r_ctx_split;
    logic [31:0] r_lo;
    logic [1:0]  r_cnt;
    logic        r_rsp_vld_p1;
    logic [31:0] r_waddr, r_wdata;
    logic [1:0]  r_wsize;

    logic [1:0]  w_off;
    logic [2:0]  w_nbytes, w_end;
    logic        w_is_io, w_bad, w_span;
    logic [1:0]  w_idx, w_last;
    logic [31:0] w_hi_sel, w_lo_sel;

    // Pick n bytes out of the {hi,lo} doubleword starting at byte off.
    function automatic logic [31:0] align_word(input logic [31:0] hi, input logic [31:0] lo,
                                               input logic [1:0] off);
        case (off)
            2'd0:    return lo;
            2'd1:    return {hi[7:0],  lo[31:8]};
            2'd2:    return {hi[15:0], lo[31:16]};
            default: return {hi[23:0], lo[31:24]};
        endcase
    endfunction

    // zext=1 selects zero extension (lbu/lhu); words are returned unchanged.
    function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] size,
                                           input logic zext);
        case (size)
            2'd0:    return zext ? {24'h0, v[7:0]}  : {{24{v[7]}},  v[7:0]};
            2'd1:    return zext ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    function automatic logic [7:0] pick_byte(input logic [31:0] v, input logic [1:0] idx);
        case (idx)
            2'd0:    return v[7:0];
            2'd1:    return v[15:8];
            2'd2:    return v[23:16];
            default: return v[31:24];
        endcase
    endfunction

    assign w_off    = i_req_addr[1:0];
    assign w_nbytes = (i_req_size == 2'd0) ? 3'd1 : (i_req_size == 2'd1) ? 3'd2 : 3'd4;
    assign w_end    = {1'b0, w_off} + w_nbytes;
    assign w_is_io  = (i_req_addr >= IO_BASE);
    // MMIO accesses are never split, so they must be naturally aligned.
    assign w_bad    = (i_req_size == 2'd3) ||
                      (w_is_io && ((i_req_size == 2'd1 && w_off[0]) ||
                                   (i_req_size == 2'd2 && w_off != 2'd0)));
    assign w_span   = !w_is_io && (w_end > 3'd4);
    // r_cnt holds the index of the byte written last cycle.
    assign w_idx    = r_cnt + 2'd1;
    assign w_last   = (r_wsize == 2'd2) ? 2'd3 : 2'd1;

    always_comb begin
        w_next         = r_state;
        o_stall        = 1'b0;
        o_misalign_err = 1'b0;
        o_mem_addr2    = 32'h0;
        o_mem_din2     = 32'h0;
        o_mem_write2   = 1'b0;
        o_mem_read2    = 1'b0;
        o_mem_sign     = 1'b0;
        o_mem_size     = 2'd0;
        case (r_state)
            S_IDLE: begin
                if (i_req_valid) begin
                    if (w_bad) begin
                        o_misalign_err = 1'b1;
                    end else if (i_req_we) begin
                        o_mem_write2 = 1'b1;
                        o_mem_addr2  = i_req_addr;
                        if (w_span) begin
                            o_mem_din2 = {24'h0, i_req_wdata[7:0]};
                            o_stall    = 1'b1;
                            w_next     = S_WRB;
                        end else begin
                            o_mem_din2 = i_req_wdata;
                            o_mem_size = i_req_size;
                            o_mem_sign = i_req_sign;
                        end
                    end else begin
                        o_mem_read2 = 1'b1;
                        o_mem_size  = 2'd2;
                        if (w_span) begin
                            o_mem_addr2 = {i_req_addr[31:2], 2'b00};
                            o_stall     = 1'b1;
                            w_next      = S_RD2;
                        end else if (w_is_io) begin
                            o_mem_addr2 = i_req_addr;
                            o_mem_size  = i_req_size;
                            o_mem_sign  = i_req_sign;
                        end else begin
                            // RAM load: fetch the raw word, align/extend on the response side.
                            o_mem_addr2 = i_req_addr;
                        end
                    end
                end
            end
            S_RD2: begin
                o_mem_read2 = 1'b1;
                o_mem_size  = 2'd2;
                o_mem_addr2 = {r_waddr[31:2], 2'b00} + 32'd4;
                w_next      = S_IDLE;
            end
            S_WRB: begin
                o_mem_write2 = 1'b1;
                o_mem_addr2  = r_waddr + {30'h0, w_idx};
                o_mem_din2   = {24'h0, pick_byte(r_wdata, w_idx)};
                if (w_idx == w_last) begin
                    w_next = S_IDLE;
                end else begin
                    o_stall = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (i_rst) begin
            // Nothing reaches memory while reset is held, including a WRB in flight.
            w_next         = S_IDLE;
            o_stall        = 1'b0;
            o_misalign_err = 1'b0;
            o_mem_write2   = 1'b0;
            o_mem_read2    = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 2'd0;
            r_ctx_off    <= 2'd0;
            r_ctx_size   <= 2'd0;
            r_ctx_sign   <= 1'b0;
            r_ctx_io     <= 1'b0;
            r_ctx_split  <= 1'b0;
            r_lo         <= 32'h0;
            r_rsp_vld_p1 <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_rsp_vld_p1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid && !w_bad) begin
                        r_waddr <= i_req_addr;
                        if (i_req_we) begin
                            r_wdata <= i_req_wdata;
                            r_wsize <= i_req_size;
                            r_cnt   <= 2'd0;
                        end else begin
                            r_ctx_off    <= w_off;
                            r_ctx_size   <= i_req_size;
                            r_ctx_sign   <= i_req_sign;
                            r_ctx_io     <= w_is_io;
                            r_ctx_split  <= 1'b0;
                            r_rsp_vld_p1 <= !w_span;
                        end
                    end
                end
                S_RD2: begin
                    r_lo         <= i_mem_dout2;
                    r_ctx_split  <= 1'b1;
                    r_rsp_vld_p1 <= 1'b1;
                end
                S_WRB: r_cnt <= w_idx;
                default: ;
            endcase
        end
    end

    // ---- response stage: registered ctx/lo plus the memory read data ----
    assign w_hi_sel = r_ctx_split ? i_mem_dout2 : 32'h0;
    assign w_lo_sel = r_ctx_split ? r_lo : i_mem_dout2;

    always_comb begin
        o_rsp_valid = r_rsp_vld_p1;
        o_rsp_rdata = 32'h0;
        if (r_rsp_vld_p1) begin
            if (r_ctx_io) begin
                o_rsp_rdata = i_mem_dout2;
            end else begin
                o_rsp_rdata = extend(align_word(w_hi_sel, w_lo_sel, r_ctx_off), r_ctx_size, r_ctx_sign);
            end
        end
    end

endmodule

// File: tb/tb_otter_mem_align_ctrl.sv
module tb_otter_mem_align_ctrl;

    localparam logic [31:0] IO_BASE = 32'h1100_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_sign = 1'b0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic [1:0]  req_size = 2'd0;
    logic        stall, rsp_valid, err, mem_write2, mem_read2, mem_sign;
    logic [31:0] rsp_rdata, mem_addr2, mem_din2;
    logic [1:0]  mem_size;
    logic [31:0] mem_dout2 = 32'h0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    otter_mem_align_ctrl #(.IO_BASE(IO_BASE)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_we(req_we),
        .i_req_addr(req_addr), .i_req_size(req_size), .i_req_sign(req_sign),
        .i_req_wdata(req_wdata), .o_stall(stall), .o_rsp_valid(rsp_valid),
        .o_rsp_rdata(rsp_rdata), .o_misalign_err(err), .o_mem_addr2(mem_addr2),
        .o_mem_din2(mem_din2), .o_mem_write2(mem_write2), .o_mem_read2(mem_read2),
        .o_mem_sign(mem_sign), .o_mem_size(mem_size), .i_mem_dout2(mem_dout2)
    );

    // Memory port 2 environment: word RAM with registered read, byte/half/word writes.
    logic [31:0] mem_w [0:255];
    logic [31:0] mmio_val = 32'h0;
    int          rd_cnt = 0;
    logic        bd_we = 1'b0;
    logic [31:0] bd_addr = 32'h0, bd_data = 32'h0;

    always @(posedge clk) begin
        logic [31:0] w;
        int sh;
        if (bd_we) mem_w[bd_addr[9:2]] <= bd_data;
        if (mem_read2) begin
            rd_cnt    <= rd_cnt + 1;
            mem_dout2 <= (mem_addr2 >= IO_BASE) ? mmio_val : mem_w[mem_addr2[9:2]];
        end
        if (mem_write2 && mem_addr2 < IO_BASE) begin
            w  = mem_w[mem_addr2[9:2]];
            sh = 8 * int'(mem_addr2[1:0]);
            case (mem_size)
                2'd0:    w[sh +: 8] = mem_din2[7:0];
                2'd1:    if (sh <= 16) w[sh +: 16] = mem_din2[15:0];
                default: w = mem_din2;
            endcase
            mem_w[mem_addr2[9:2]] <= w;
        end
    end

    // Reference model: byte-addressed memory image, little-endian.
    logic [7:0] ref_b [0:1023];

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] s, input logic zext);
        logic [31:0] v = 32'h0;
        int n = nbytes(s);
        for (int i = 0; i < n; i++) v = v | (32'(ref_b[int'(a[9:0]) + i]) << (8 * i));
        if (n == 4 || zext) return v;
        if (n == 1) return (v >= 32'h80) ? (v | 32'hFFFF_FF00) : v;
        return (v >= 32'h8000) ? (v | 32'hFFFF_0000) : v;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return {ref_b[int'(a[9:0]) + 3], ref_b[int'(a[9:0]) + 2], ref_b[int'(a[9:0]) + 1], ref_b[int'(a[9:0])]};
    endfunction

    function automatic bit spans(input logic [31:0] a, input logic [1:0] s);
        return (int'(a[1:0]) + nbytes(s)) > 4;
    endfunction

    task automatic ref_store(input logic [31:0] a, input int n, input logic [31:0] d);
        for (int i = 0; i < n; i++) ref_b[int'(a[9:0]) + i] = d[8*i +: 8];
    endtask

    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        bd_we = 1'b1; bd_addr = a; bd_data = v;
        @(posedge clk); #1;
        bd_we = 1'b0;
        ref_store(a, 4, v);
    endtask

    task automatic run_load(input logic [31:0] a, input logic [1:0] s, input logic sg,
                            output int stalls, output int lat, output logic [31:0] data, output bit got);
        int cyc = 0;
        logic st;
        stalls = 0; lat = -1; data = 32'h0; got = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_size = s; req_sign = sg;
        do begin
            @(negedge clk); st = stall;
            if (st) stalls++;
            @(posedge clk); #1; cyc++;
        end while (st && cyc < 10);
        req_valid = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) begin got = 1'b1; data = rsp_rdata; lat = cyc; end
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic run_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d,
                             output int stalls, output int writes);
        int cyc = 0;
        logic st;
        stalls = 0; writes = 0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_size = s; req_sign = 1'b0; req_wdata = d;
        do begin
            @(negedge clk); st = stall;
            if (st) stalls++;
            if (mem_write2) writes++;
            @(posedge clk); #1; cyc++;
        end while (st && cyc < 10);
        req_valid = 1'b0; req_we = 1'b0;
        ref_store(a, nbytes(s), d);
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h101; req_size = 2'd2;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({mem_read2, mem_write2, stall, err} !== 4'b0) begin
                errors++;
                $display("FAIL reset_quiet rd/wr/stall/err=%b required 0000", {mem_read2, mem_write2, stall, err});
            end
            @(posedge clk); #1;
        end
        rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({rsp_valid, stall, err, mem_read2, mem_write2} !== 5'b0 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_state ctl=%b rdata=%h required 00000/00000000",
                     {rsp_valid, stall, err, mem_read2, mem_write2}, rsp_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_span_load();
        int st, lat; logic [31:0] d; bit got;
        logic [31:0] exp = ref_load(32'h101, 2'd2, 1'b0);
        run_load(32'h101, 2'd2, 1'b0, st, lat, d, got);
        checks++;
        if (st != 1 || lat != 2 || !got) begin
            errors++; $display("FAIL span_lw_timing stalls=%0d lat=%0d got=%0d required 1/2/1", st, lat, got);
        end
        checks++;
        if (d !== exp) begin errors++; $display("FAIL span_lw_data got %h required %h", d, exp); end
    endtask

    task automatic test_partial_loads();
        logic [31:0] a_t [3] = '{32'h103, 32'h103, 32'h102};
        logic [1:0]  s_t [3] = '{2'd1, 2'd1, 2'd0};
        logic        z_t [3] = '{1'b0, 1'b1, 1'b0};
        int st, lat; logic [31:0] d, exp; bit got;
        for (int i = 0; i < 3; i++) begin
            exp = ref_load(a_t[i], s_t[i], z_t[i]);
            run_load(a_t[i], s_t[i], z_t[i], st, lat, d, got);
            checks++;
            if (st != (spans(a_t[i], s_t[i]) ? 1 : 0) || lat != (spans(a_t[i], s_t[i]) ? 2 : 1) || !got) begin
                errors++; $display("FAIL partial_timing_%0d stalls=%0d lat=%0d got=%0d", i, st, lat, got);
            end
            checks++;
            if (d !== exp) begin errors++; $display("FAIL partial_data_%0d got %h required %h", i, d, exp); end
        end
    endtask

    task automatic test_span_store();
        int st, wr;
        run_store(32'h102, 2'd2, 32'hAABBCCDD, st, wr);
        checks++;
        if (st != 3 || wr != 4) begin
            errors++; $display("FAIL span_sw_timing stalls=%0d writes=%0d required 3/4", st, wr);
        end
        checks++;
        if (mem_w[32'h100 >> 2] !== ref_word(32'h100) || mem_w[32'h104 >> 2] !== ref_word(32'h104)) begin
            errors++;
            $display("FAIL span_sw_mem got %h %h required %h %h", mem_w[32'h100 >> 2], mem_w[32'h104 >> 2],
                     ref_word(32'h100), ref_word(32'h104));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e0 = ref_load(32'h101, 2'd2, 1'b0);
        logic [31:0] e1 = ref_load(32'h100, 2'd2, 1'b0);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h101; req_size = 2'd2; req_sign = 1'b0;
        @(negedge clk);
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL b2b_stall0 got %b required 1", stall); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_rd2 stall=%b rsp=%b required 0/0", stall, rsp_valid);
        end
        @(posedge clk); #1;
        req_addr = 32'h100;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== e0 || stall !== 1'b0) begin
            errors++; $display("FAIL b2b_rsp0 vld=%b data=%h stall=%b required 1/%h/0", rsp_valid, rsp_rdata, stall, e0);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== e1) begin
            errors++; $display("FAIL b2b_rsp1 vld=%b data=%h required 1/%h", rsp_valid, rsp_rdata, e1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mmio_and_errors();
        int st, lat, r0; logic [31:0] d; bit got;
        mmio_val = 32'hDEADBEEF;
        r0 = rd_cnt;
        run_load(IO_BASE, 2'd2, 1'b0, st, lat, d, got);
        checks++;
        if (d !== 32'hDEADBEEF || st != 0 || lat != 1 || (rd_cnt - r0) != 1) begin
            errors++; $display("FAIL mmio_lw data=%h stalls=%0d lat=%0d reads=%0d required deadbeef/0/1/1",
                               d, st, lat, rd_cnt - r0);
        end
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100; req_size = 2'd3;
        @(negedge clk);
        checks++;
        if ({err, mem_read2, mem_write2, stall} !== 4'b1000) begin
            errors++; $display("FAIL size3_err err/rd/wr/stall=%b required 1000", {err, mem_read2, mem_write2, stall});
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL size3_after err=%b rsp=%b required 0/0", err, rsp_valid);
        end
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = IO_BASE + 32'd2; req_size = 2'd2; req_wdata = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if ({err, mem_read2, mem_write2, stall} !== 4'b1000) begin
            errors++; $display("FAIL io_misalign err/rd/wr/stall=%b required 1000", {err, mem_read2, mem_write2, stall});
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0;
    endtask

    task automatic test_reset_mid_wrb();
        set_word(32'h100, 32'h44332211);
        set_word(32'h104, 32'h88776685);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h102; req_size = 2'd2; req_wdata = 32'hAABBCCDD;
        repeat (2) begin @(negedge clk); @(posedge clk); #1; end
        ref_store(32'h102, 2, 32'hAABBCCDD);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_write2 !== 1'b0 || mem_read2 !== 1'b0) begin
            errors++; $display("FAIL rst_wrb_quiet wr=%b rd=%b required 0/0", mem_write2, mem_read2);
        end
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_write2 !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL rst_wrb_idle wr=%b stall=%b required 0/0", mem_write2, stall);
        end
        @(posedge clk); #1;
        checks++;
        if (mem_w[32'h100 >> 2] !== ref_word(32'h100) || mem_w[32'h104 >> 2] !== ref_word(32'h104)) begin
            errors++;
            $display("FAIL rst_wrb_mem got %h %h required %h %h", mem_w[32'h100 >> 2], mem_w[32'h104 >> 2],
                     ref_word(32'h100), ref_word(32'h104));
        end
    endtask

    task automatic test_random();
        int st, lat, wr; logic [31:0] a, d, exp, wd; logic [1:0] s; logic z; bit got;
        for (int i = 0; i < 80; i++) begin
            a = 32'h100 + 32'($urandom_range(0, 32'hF8));
            s = 2'($urandom_range(0, 2));
            z = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) begin
                exp = ref_load(a, s, z);
                run_load(a, s, z, st, lat, d, got);
                checks++;
                if (!got || d !== exp || st != (spans(a, s) ? 1 : 0) || lat != (spans(a, s) ? 2 : 1)) begin
                    errors++;
                    $display("FAIL rnd_load a=%h s=%0d z=%0d data=%h required %h stalls=%0d lat=%0d got=%0d",
                             a, s, z, d, exp, st, lat, got);
                end
            end else begin
                wd = $urandom;
                run_store(a, s, wd, st, wr);
                checks++;
                if (st != (spans(a, s) ? nbytes(s) - 1 : 0) || wr != (spans(a, s) ? nbytes(s) : 1)) begin
                    errors++; $display("FAIL rnd_store a=%h s=%0d stalls=%0d writes=%0d", a, s, st, wr);
                end
            end
        end
        for (int w = 32'h100; w < 32'h200; w += 4) begin
            checks++;
            if (mem_w[w >> 2] !== ref_word(32'(w))) begin
                errors++; $display("FAIL rnd_mem @%h got %h required %h", w, mem_w[w >> 2], ref_word(32'(w)));
            end
        end
    endtask

    initial begin
        for (int w = 32'h100; w < 32'h200; w += 4) set_word(32'(w), $urandom);
        set_word(32'h100, 32'h44332211);
        set_word(32'h104, 32'h88776685);
        test_reset();
        test_span_load();
        test_partial_loads();
        test_back_to_back();
        test_span_store();
        test_mmio_and_errors();
        test_reset_mid_wrb();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
